// File: rtl/apsk_minsearch_llr.sv
// Streaming max-log LLR engine for 16/32/64-APSK exhaustive demapping.
// Tracks per-bit, per-value running minima over LANES metrics per beat and emits min1 - min0.
module apsk_minsearch_llr #(
    parameter int unsigned wordlength     = 18,
    parameter int unsigned LLR_wordlength = 19,
    parameter int unsigned bit_num        = 6,
    parameter int unsigned LANES          = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [1:0]                        mode,
    input  logic                              clr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*wordlength-1:0]       in_metric,
    input  logic [LANES*bit_num-1:0]          in_label,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [bit_num*LLR_wordlength-1:0] out_llr
);

    localparam int unsigned LaneShift = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int unsigned CntW      = 7;

    typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

    state_e                              state_q, state_d;
    logic [1:0]                          mode_q, mode_d;
    logic [CntW-1:0]                     beat_cnt_q, beat_cnt_d;
    logic [wordlength-1:0]               min0_q [bit_num];
    logic [wordlength-1:0]               min1_q [bit_num];
    logic [wordlength-1:0]               min0_d [bit_num];
    logic [wordlength-1:0]               min1_d [bit_num];
    logic [wordlength-1:0]               cand0  [bit_num];
    logic [wordlength-1:0]               cand1  [bit_num];
    logic [bit_num*LLR_wordlength-1:0]   out_llr_q, out_llr_d;

    logic [2:0]      nbits_cur;
    logic [CntW-1:0] beats_cur;
    logic            last_beat;

    function automatic logic [2:0] nbits_of(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd4;
            2'd1:    return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    // The first beat of a symbol uses the live mode input; later beats use the latched copy.
    always_comb begin
        nbits_cur = (state_q == StIdle) ? nbits_of(mode) : nbits_of(mode_q);
        beats_cur = (CntW'(1) << nbits_cur) >> LaneShift;
        last_beat = (state_q == StIdle) ? (beats_cur == CntW'(1))
                                        : (beat_cnt_q == beats_cur - CntW'(1));
    end

    // Fold this beat's lanes into each hypothesis; strict < keeps the earlier value on ties.
    always_comb begin
        for (int b = 0; b < int'(bit_num); b++) begin
            cand0[b] = (state_q == StIdle) ? '1 : min0_q[b];
            cand1[b] = (state_q == StIdle) ? '1 : min1_q[b];
            for (int k = 0; k < int'(LANES); k++) begin
                if (in_label[k*bit_num + b]) begin
                    if (in_metric[k*wordlength +: wordlength] < cand1[b]) begin
                        cand1[b] = in_metric[k*wordlength +: wordlength];
                    end
                end else begin
                    if (in_metric[k*wordlength +: wordlength] < cand0[b]) begin
                        cand0[b] = in_metric[k*wordlength +: wordlength];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        beat_cnt_d = beat_cnt_q;
        out_llr_d  = out_llr_q;
        for (int b = 0; b < int'(bit_num); b++) begin
            min0_d[b] = min0_q[b];
            min1_d[b] = min1_q[b];
        end

        if (clr) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (in_valid) begin
                        if (state_q == StIdle) begin
                            mode_d     = mode;
                            beat_cnt_d = CntW'(1);
                        end else begin
                            beat_cnt_d = beat_cnt_q + CntW'(1);
                        end
                        for (int b = 0; b < int'(bit_num); b++) begin
                            if (b < int'(nbits_cur)) begin
                                min0_d[b] = cand0[b];
                                min1_d[b] = cand1[b];
                            end
                        end
                        if (last_beat) begin
                            state_d = StOut;
                            for (int b = 0; b < int'(bit_num); b++) begin
                                if (b < int'(nbits_cur)) begin
                                    out_llr_d[b*LLR_wordlength +: LLR_wordlength] =
                                        {1'b0, cand1[b]} - {1'b0, cand0[b]};
                                end else begin
                                    out_llr_d[b*LLR_wordlength +: LLR_wordlength] = '0;
                                end
                            end
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state_d    = StIdle;
                        beat_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            beat_cnt_q <= '0;
            out_llr_q  <= '0;
            for (int b = 0; b < int'(bit_num); b++) begin
                min0_q[b] <= '1;
                min1_q[b] <= '1;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            beat_cnt_q <= beat_cnt_d;
            out_llr_q  <= out_llr_d;
            for (int b = 0; b < int'(bit_num); b++) begin
                min0_q[b] <= min0_d[b];
                min1_q[b] <= min1_d[b];
            end
        end
    end

    assign in_ready  = (state_q != StOut);
    assign out_valid = (state_q == StOut);
    assign out_llr   = out_llr_q;

endmodule

// File: tb/tb_apsk_minsearch_llr.sv
// Directed bench for apsk_minsearch_llr: expected LLR vectors are queued when a symbol is
// driven and popped when out_valid is seen.
module tb_apsk_minsearch_llr;

    localparam int W  = 18;
    localparam int LW = 19;
    localparam int BN = 6;
    localparam int L  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [L*W-1:0]    in_metric = '0;
    logic [L*BN-1:0]   in_label = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BN*LW-1:0]  out_llr;

    int checks = 0;
    int failures = 0;

    int               lab [64];
    logic [W-1:0]     met [64];
    logic [BN*LW-1:0] exp_q [$];
    logic [BN*LW-1:0] last_llr;
    logic [BN*LW-1:0] held;
    logic [LW-1:0]    neg;

    apsk_minsearch_llr #(
        .wordlength    (W),
        .LLR_wordlength(LW),
        .bit_num       (BN),
        .LANES         (L)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_metric(in_metric),
        .in_label (in_label),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_llr  (out_llr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nb_of(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 5 : 6;
    endfunction

    // Reference max-log LLR over the first 2^nb entries of lab/met.
    function automatic logic [BN*LW-1:0] model(input int nb);
        logic [BN*LW-1:0] r;
        int m0, m1, d;
        r = '0;
        for (int b = 0; b < nb; b++) begin
            m0 = (1 << W) - 1;
            m1 = (1 << W) - 1;
            for (int i = 0; i < (1 << nb); i++) begin
                if (((lab[i] >> b) & 1) == 1) begin
                    if (int'(met[i]) < m1) m1 = int'(met[i]);
                end else begin
                    if (int'(met[i]) < m0) m0 = int'(met[i]);
                end
            end
            d = m1 - m0;
            r[b*LW +: LW] = LW'(d);
        end
        return r;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        if (!in_ready) chk("ready_timeout", {127'b0, in_ready}, 128'd1);
    endtask

    // Drives up to 'limit' beats; a complete symbol also queues its expected vector.
    task automatic send_beats(input logic [1:0] m, input int limit);
        int nb, beats;
        nb = nb_of(m);
        beats = (1 << nb) / L;
        chk("ready_at_start", {127'b0, in_ready}, 128'd1);
        if (limit >= beats) exp_q.push_back(model(nb));
        for (int j = 0; j < beats && j < limit; j++) begin
            mode = (j == 0) ? m : ~m;
            in_valid = 1'b1;
            for (int k = 0; k < L; k++) begin
                in_metric[k*W +: W]  = met[j*L + k];
                in_label[k*BN +: BN] = BN'(lab[j*L + k]);
            end
            wait_ready();
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        logic [BN*LW-1:0] e;
        chk({tag, "_valid"}, {127'b0, out_valid}, 128'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_llr"}, {14'b0, out_llr}, {14'b0, e});
        last_llr = out_llr;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done"}, {127'b0, out_valid}, 128'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_llr", {14'b0, out_llr}, 128'd0);
        rst_n = 1'b1;
        tick();

        // Mode 0, ordered labels, metric = 10*label
        for (int i = 0; i < 16; i++) begin
            lab[i] = i;
            met[i] = W'(10 * i);
        end
        send_beats(2'd0, 99);
        collect("m0_seq");
        for (int b = 0; b < BN; b++)
            chk("m0_seq_const", {109'b0, last_llr[b*LW +: LW]}, (b < 4) ? 128'(10 << b) : 128'd0);

        // Mode 2, scrambled Gray labels, random metrics
        for (int i = 0; i < 64; i++) begin
            int p;
            p = (i * 37) % 64;
            lab[i] = p ^ (p >> 1);
            met[i] = W'($urandom_range(0, (1 << W) - 1));
        end
        send_beats(2'd2, 99);
        collect("m2_gray");

        // Reserved mode 3 behaves as 64-APSK
        for (int i = 0; i < 64; i++) begin
            lab[i] = 63 - i;
            met[i] = W'($urandom);
        end
        send_beats(2'd3, 99);
        collect("m3_rsv");

        // Extreme difference: only label 63 is small
        for (int i = 0; i < 64; i++) begin
            lab[i] = i;
            met[i] = (i == 63) ? W'(1000) : '1;
        end
        send_beats(2'd2, 99);
        collect("m2_ext");
        neg = LW'(-261143);
        for (int b = 0; b < BN; b++)
            chk("m2_ext_const", {109'b0, last_llr[b*LW +: LW]}, {109'b0, neg});

        // Ties: duplicate label 0 in a later beat, all one-hot labels at the same metric
        for (int i = 0; i < 16; i++) begin
            lab[i] = i;
            met[i] = (i == 0 || i == 1 || i == 2 || i == 4 || i == 8) ? W'(5) : W'(100);
        end
        lab[15] = 0;
        met[15] = W'(5);
        send_beats(2'd0, 99);
        collect("tie");
        chk("tie_zero", {14'b0, last_llr}, 128'd0);

        // Backpressure with the next symbol's first beat already offered
        for (int i = 0; i < 32; i++) begin
            lab[i] = (i * 13) % 32;
            met[i] = W'($urandom);
        end
        send_beats(2'd1, 99);
        held = out_llr;
        for (int i = 0; i < 16; i++) begin
            lab[i] = (i * 7) % 16;
            met[i] = W'($urandom);
        end
        mode = 2'd0;
        in_valid = 1'b1;
        for (int k = 0; k < L; k++) begin
            in_metric[k*W +: W]  = met[k];
            in_label[k*BN +: BN] = BN'(lab[k]);
        end
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("bp_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_ready", {127'b0, in_ready}, 128'd0);
            chk("bp_hold", {14'b0, out_llr}, {14'b0, held});
        end
        collect("bp");
        send_beats(2'd0, 99);
        collect("bp_next");

        // clr on beat 3 of a mode-1 symbol
        for (int i = 0; i < 32; i++) begin
            lab[i] = (i * 21) % 32;
            met[i] = W'($urandom);
        end
        send_beats(2'd1, 2);
        mode = 2'd1;
        in_valid = 1'b1;
        clr = 1'b1;
        for (int k = 0; k < L; k++) begin
            in_metric[k*W +: W]  = met[8 + k];
            in_label[k*BN +: BN] = BN'(lab[8 + k]);
        end
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", {127'b0, out_valid}, 128'd0);
        chk("clr_ready", {127'b0, in_ready}, 128'd1);
        for (int i = 0; i < 32; i++) begin
            lab[i] = (i * 11) % 32;
            met[i] = W'($urandom);
        end
        send_beats(2'd1, 99);
        collect("clr_next");

        // Asynchronous reset mid-accumulation
        for (int i = 0; i < 64; i++) begin
            lab[i] = (i * 5) % 64;
            met[i] = W'($urandom);
        end
        send_beats(2'd2, 3);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {127'b0, in_ready}, 128'd1);
        chk("arst_valid", {127'b0, out_valid}, 128'd0);
        chk("arst_llr", {14'b0, out_llr}, 128'd0);
        #1;
        rst_n = 1'b1;
        tick();

        // Back-to-back 64-APSK symbols
        send_beats(2'd2, 99);
        collect("b2b_a");
        for (int i = 0; i < 64; i++) begin
            lab[i] = (i * 27) % 64;
            met[i] = W'($urandom);
        end
        send_beats(2'd2, 99);
        collect("b2b_b");

        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apsk_minsearch_llr.md
# apsk_minsearch_llr

Streaming, mode-programmable max-log LLR engine for the APSK exhaustive demapper. Per received symbol it accepts the full set of candidate distance metrics LANES at a time, each tagged with its constellation bit label. It keeps a running minimum per bit position and per bit value, then emits signed LLRs (min over bit=1 minus min over bit=0). It follows the distance-metric stage and replaces the fixed-routing, 64-APSK-only comparison unit with one time-multiplexed datapath covering 16-, 32- and 64-APSK.

## Interface
- wordlength, 18, unsigned metric width
- LLR_wordlength, 19, signed LLR width (must equal wordlength+1)
- bit_num, 6, maximum bits per symbol
- LANES, 4, metrics accepted per beat; power of two, 1..16
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  0: 16-APSK (4 bits), 1: 32-APSK (5 bits), 2: 64-APSK (6 bits), 3: reserved, treated as 2
- clr  in  1  synchronous abort; discards any partial symbol
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_metric  in  LANES*wordlength  lane k at [k*wordlength +: wordlength]
- in_label  in  LANES*bit_num  lane k label at [k*bit_num +: bit_num]
- out_valid  out  1  LLR vector valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_llr  out  bit_num*LLR_wordlength  bit b at [b*LLR_wordlength +: LLR_wordlength], two's complement

## Operation
- States: IDLE, ACCUM, OUT.
- IDLE: in_ready=1. The first accepted beat latches mode into mode_r and sets nbits (4/5/6) and beats = 2^nbits/LANES. It sets beat_cnt=1 and loads the min registers from that beat alone, with no prior state. Next state is ACCUM, or OUT if beats==1.
- ACCUM: in_ready=1. On each accepted beat, for each b < nbits and v in {0,1}: min_v[b] = minimum of min_v[b] and the metrics of all lanes whose in_label bit b == v.
  - A hypothesis with no matching lane in a beat keeps its value.
  - Compare is strict less-than: on ties the earlier value is kept.
  - beat_cnt increments per accepted beat. On the beat where beat_cnt == beats-1, the final mins are written and the state moves to OUT.
- mode changes during ACCUM/OUT are ignored until the next IDLE first beat.
- Min registers are initialised to all-ones (2^wordlength-1) when no lane in the first beat matches a hypothesis.
- OUT: out_valid=1, in_ready=0.
  - out_llr[b] = {1'b0,min_1[b]} - {1'b0,min_0[b]} for b < nbits; 0 for b >= nbits.
  - The subtraction is exact at wordlength+1 bits, so there is no saturation.
  - out_llr is held stable while out_valid && !out_ready. On the handshake the state moves to IDLE.
- Label bits at positions >= nbits are ignored.
- The labels of one symbol must be a permutation of 0..2^nbits-1. This is not checked; the result is undefined otherwise.
- clr: from any state, the next state is IDLE, beat_cnt=0 and out_valid=0; any pending output is dropped. clr has priority over a simultaneous beat or out handshake, and the beat is not consumed.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_llr=0, beat_cnt=0, min registers all-ones, mode_r=0.
- in_ready is combinational from state only: high in IDLE/ACCUM, low in OUT. It has no dependency on in_valid.
- Latency: out_valid rises the cycle after the last beat is accepted. out_llr is registered and valid the same cycle out_valid rises.
- Throughput: beats+1 cycles per symbol with out_ready tied high, i.e. one bubble cycle in OUT. For 64-APSK, LANES=4, that is 17 cycles.
- Back-to-back: the cycle after the OUT handshake, IDLE accepts the next symbol's first beat.
- in_valid gaps in ACCUM stall accumulation with no state change.
- Asynchronous reset mid-symbol clears everything immediately; the partial symbol is lost.

## Test plan
- Mode 0, LANES=4, 4 beats, labels 0..15 in order, metric = 10*label.
  - Required: out_llr = {80,40,20,10} for bits 3..0, and bits 4,5 = 0.
  - out_valid rises 1 cycle after beat 4.
- Mode 2, 16 beats, 64-APSK Gray labels in scrambled order, random metrics.
  - Required: out_llr matches a software max-log reference bit-exactly.
- Mode 2, labels 0..63, metric = 1000 for label 63 and 2^18-1 for all others.
  - Required: every out_llr[b] = 1000-(2^18-1) = -261143.
- Tie case: two label-0 candidates with metric 5 in different beats; all label bit b=1 metrics are 5.
  - Required: out_llr = 0.
- Backpressure: hold out_ready=0 for 7 cycles with in_valid=1.
  - Required: out_llr stable, in_ready=0, no beat consumed. The next symbol starts the cycle after out_ready=1.
- clr asserted on beat 3 of a mode-1 symbol with in_valid=1.
  - Required: no out_valid for that symbol. The next 8-beat symbol gives correct LLRs with mode_r re-latched.
- Async reset during ACCUM.
  - Required: in_ready=1 and out_valid=0 immediately.
